// File: rtl/eth_tx_frame_arb.sv
// ----------------------------------------------------------------------------
// eth_tx_frame_arb
//
// Purpose:
//   N-channel Ethernet transmit frame arbiter. It grants one channel per frame
//   and forwards that channel's Ethernet header, followed by its payload
//   stream, as one coherent frame. A channel flagged in RAW_MASK supplies
//   payload only. For such a channel the header is built here from
//   RAW_DEST_MAC, local_mac and RAW_ETH_TYPE.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   s_eth_hdr_valid/ready       per-channel header handshake (raw: unused)
//   s_eth_dest_mac/src_mac/type per-channel header fields, channel 0 in LSBs
//   s_eth_payload_axis_*        per-channel payload AXI-Stream
//   local_mac                   source MAC inserted for raw channels
//   m_eth_hdr_*                 granted header towards the transmitter
//   m_eth_payload_axis_*        granted payload towards the transmitter
//   m_sel                       channel currently granted
//   busy                        high while a frame is granted
// ----------------------------------------------------------------------------
module eth_tx_frame_arb #(
  parameter int                  CHANNELS     = 2,
  parameter int                  DATA_WIDTH   = 8,
  parameter string               ARB_MODE     = "ROUND_ROBIN",
  parameter logic [CHANNELS-1:0] RAW_MASK     = '0,
  parameter logic [15:0]         RAW_ETH_TYPE = 16'h88F7,
  parameter logic [47:0]         RAW_DEST_MAC = 48'h011B19000000,
  parameter int                  SEL_WIDTH    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS-1:0]            s_eth_hdr_valid,
  output logic [CHANNELS-1:0]            s_eth_hdr_ready,
  input  logic [CHANNELS*48-1:0]         s_eth_dest_mac,
  input  logic [CHANNELS*48-1:0]         s_eth_src_mac,
  input  logic [CHANNELS*16-1:0]         s_eth_type,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic [CHANNELS-1:0]            s_eth_payload_axis_tvalid,
  output logic [CHANNELS-1:0]            s_eth_payload_axis_tready,
  input  logic [CHANNELS-1:0]            s_eth_payload_axis_tlast,
  input  logic [CHANNELS-1:0]            s_eth_payload_axis_tuser,
  input  logic [47:0]                    local_mac,
  output logic                           m_eth_hdr_valid,
  input  logic                           m_eth_hdr_ready,
  output logic [47:0]                    m_eth_dest_mac,
  output logic [47:0]                    m_eth_src_mac,
  output logic [15:0]                    m_eth_type,
  output logic [DATA_WIDTH-1:0]          m_eth_payload_axis_tdata,
  output logic                           m_eth_payload_axis_tvalid,
  input  logic                           m_eth_payload_axis_tready,
  output logic                           m_eth_payload_axis_tlast,
  output logic                           m_eth_payload_axis_tuser,
  output logic [SEL_WIDTH-1:0]           m_sel,
  output logic                           busy
);

  localparam bit ROUND_ROBIN = (ARB_MODE == "ROUND_ROBIN");

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD
  } state_t;

  state_t                 state, state_next;
  logic [SEL_WIDTH-1:0]   sel;
  logic [SEL_WIDTH-1:0]   rr_ptr;
  logic [SEL_WIDTH-1:0]   arb_base;
  logic [47:0]            dest_q, src_q;
  logic [15:0]            type_q;

  logic [CHANNELS-1:0]    req;
  logic                   any_req;
  logic [SEL_WIDTH-1:0]   win_idx;
  logic                   win_raw;
  logic [47:0]            win_dest, win_src;
  logic [15:0]            win_type;
  logic                   grant;
  logic                   frame_done;

  // (base + off) mod CHANNELS, narrowed to a channel index.
  function automatic logic [SEL_WIDTH-1:0] wrap_idx(input int base, input int off);
    return SEL_WIDTH'((base + off) % CHANNELS);
  endfunction

  // A raw channel requests with its first payload beat; any other channel
  // requests with its header.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      req[i] = RAW_MASK[i] ? s_eth_payload_axis_tvalid[i] : s_eth_hdr_valid[i];
    end
  end

  // Priority mode always scans from channel 0. Round-robin mode starts the
  // scan at the pointer and wraps.
  assign arb_base = ROUND_ROBIN ? rr_ptr : '0;

  // NOTE: every signal driven here gets a default before any conditional
  //       assignment, so no path leaves a value unassigned (no latches).
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!any_req && req[wrap_idx(int'(arb_base), k)]) begin
        any_req = 1'b1;
        win_idx = wrap_idx(int'(arb_base), k);
      end
    end
  end

  // Header of the winning channel. A raw channel uses the generated fields.
  always_comb begin
    win_raw  = RAW_MASK[win_idx];
    win_dest = RAW_DEST_MAC;
    win_src  = local_mac;
    win_type = RAW_ETH_TYPE;
    if (!win_raw) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (win_idx == SEL_WIDTH'(i)) begin
          win_dest = s_eth_dest_mac[i*48 +: 48];
          win_src  = s_eth_src_mac[i*48 +: 48];
          win_type = s_eth_type[i*16 +: 16];
        end
      end
    end
  end

  assign grant = (state == ST_IDLE) && any_req;

  // Payload pass-through from the granted channel only. Every source's
  // tready stays low outside PAYLOAD, so a raw channel's first beat is
  // held at its source until the header has gone out.
  always_comb begin
    m_eth_payload_axis_tdata  = '0;
    m_eth_payload_axis_tvalid = 1'b0;
    m_eth_payload_axis_tlast  = 1'b0;
    m_eth_payload_axis_tuser  = 1'b0;
    s_eth_payload_axis_tready = '0;
    if (state == ST_PAYLOAD) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_WIDTH'(i)) begin
          m_eth_payload_axis_tdata     = s_eth_payload_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
          m_eth_payload_axis_tvalid    = s_eth_payload_axis_tvalid[i];
          m_eth_payload_axis_tlast     = s_eth_payload_axis_tlast[i];
          m_eth_payload_axis_tuser     = s_eth_payload_axis_tuser[i];
          s_eth_payload_axis_tready[i] = m_eth_payload_axis_tready;
        end
      end
    end
  end

  assign frame_done = (state == ST_PAYLOAD) && m_eth_payload_axis_tvalid &&
                      m_eth_payload_axis_tready && m_eth_payload_axis_tlast;

  // Next state and the one-cycle header accept pulse. The pulse is masked
  // while rst is high, because the register would not capture the header
  // in that cycle.
  always_comb begin
    state_next      = state;
    s_eth_hdr_ready = '0;
    unique case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_next = ST_HDR;
          if (!win_raw && !rst) begin
            s_eth_hdr_ready[win_idx] = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (m_eth_hdr_ready) begin
          state_next = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (frame_done) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  //       register samples the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The grant and header capture registers are reset as well, so that
  // m_sel and the header outputs read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel    <= '0;
      rr_ptr <= '0;
      dest_q <= '0;
      src_q  <= '0;
      type_q <= '0;
    end else begin
      if (grant) begin
        sel    <= win_idx;
        dest_q <= win_dest;
        src_q  <= win_src;
        type_q <= win_type;
      end
      if (frame_done && ROUND_ROBIN) begin
        rr_ptr <= wrap_idx(int'(sel), 1);
      end
    end
  end

  assign m_eth_hdr_valid = (state == ST_HDR);
  assign m_eth_dest_mac  = dest_q;
  assign m_eth_src_mac   = src_q;
  assign m_eth_type      = type_q;
  assign m_sel           = sel;
  assign busy            = (state != ST_IDLE);

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
// ----------------------------------------------------------------------------
// tb_eth_tx_frame_arb
//
// Self-checking bench for eth_tx_frame_arb.
//
// The main DUT has 4 channels in round-robin mode. Channels 0 and 2 are raw.
// It is driven by random frame sources and random downstream back-pressure.
// The reference model works per frame:
//   - it picks a winner from the request vector using the arbitration rule;
//   - it predicts the header;
//   - it follows the beats of the granted frame.
// Resets are injected in the middle of frames.
//
// A second DUT has 2 channels in priority mode. Both of its channels request
// all the time, so every grant must go to channel 0.
// ----------------------------------------------------------------------------
module tb_eth_tx_frame_arb;

  localparam int         CH   = 4;
  localparam int         DW   = 8;
  localparam logic [3:0] RAW  = 4'b0101;
  localparam int         NCYC = 6000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic [CH-1:0]    s_eth_hdr_valid = '0;
  logic [CH-1:0]    s_eth_hdr_ready;
  logic [CH*48-1:0] s_eth_dest_mac = '0;
  logic [CH*48-1:0] s_eth_src_mac = '0;
  logic [CH*16-1:0] s_eth_type = '0;
  logic [CH*DW-1:0] s_eth_payload_axis_tdata = '0;
  logic [CH-1:0]    s_eth_payload_axis_tvalid = '0;
  logic [CH-1:0]    s_eth_payload_axis_tready;
  logic [CH-1:0]    s_eth_payload_axis_tlast = '0;
  logic [CH-1:0]    s_eth_payload_axis_tuser = '0;
  logic [47:0]      local_mac = 48'h02005E123456;
  logic             m_eth_hdr_valid;
  logic             m_eth_hdr_ready = 1'b0;
  logic [47:0]      m_eth_dest_mac, m_eth_src_mac;
  logic [15:0]      m_eth_type;
  logic [DW-1:0]    m_eth_payload_axis_tdata;
  logic             m_eth_payload_axis_tvalid;
  logic             m_eth_payload_axis_tready = 1'b0;
  logic             m_eth_payload_axis_tlast;
  logic             m_eth_payload_axis_tuser;
  logic [1:0]       m_sel;
  logic             busy;

  eth_tx_frame_arb #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .ARB_MODE("ROUND_ROBIN"), .RAW_MASK(RAW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
    .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac),
    .s_eth_type(s_eth_type),
    .s_eth_payload_axis_tdata(s_eth_payload_axis_tdata),
    .s_eth_payload_axis_tvalid(s_eth_payload_axis_tvalid),
    .s_eth_payload_axis_tready(s_eth_payload_axis_tready),
    .s_eth_payload_axis_tlast(s_eth_payload_axis_tlast),
    .s_eth_payload_axis_tuser(s_eth_payload_axis_tuser),
    .local_mac(local_mac),
    .m_eth_hdr_valid(m_eth_hdr_valid), .m_eth_hdr_ready(m_eth_hdr_ready),
    .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac),
    .m_eth_type(m_eth_type),
    .m_eth_payload_axis_tdata(m_eth_payload_axis_tdata),
    .m_eth_payload_axis_tvalid(m_eth_payload_axis_tvalid),
    .m_eth_payload_axis_tready(m_eth_payload_axis_tready),
    .m_eth_payload_axis_tlast(m_eth_payload_axis_tlast),
    .m_eth_payload_axis_tuser(m_eth_payload_axis_tuser),
    .m_sel(m_sel), .busy(busy)
  );

  // ---------------- priority DUT (constant saturating stimulus) ----------------
  logic [1:0]  p_hdr_ready, p_tready;
  logic        p_hdr_valid_m, p_tvalid_m, p_tlast_m, p_tuser_m, p_busy;
  logic [47:0] p_dest_m, p_src_m;
  logic [15:0] p_type_m;
  logic [7:0]  p_tdata_m;
  logic [0:0]  p_sel;

  eth_tx_frame_arb #(
    .CHANNELS(2), .DATA_WIDTH(8), .ARB_MODE("PRIORITY"), .RAW_MASK(2'b00)
  ) dut_prio (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(2'b11), .s_eth_hdr_ready(p_hdr_ready),
    .s_eth_dest_mac({48'h0000000000B1, 48'h0000000000A0}),
    .s_eth_src_mac({48'h0000000000B2, 48'h0000000000A2}),
    .s_eth_type({16'h86DD, 16'h0800}),
    .s_eth_payload_axis_tdata({8'hB3, 8'hA3}),
    .s_eth_payload_axis_tvalid(2'b11),
    .s_eth_payload_axis_tready(p_tready),
    .s_eth_payload_axis_tlast(2'b11),
    .s_eth_payload_axis_tuser(2'b00),
    .local_mac(48'h0),
    .m_eth_hdr_valid(p_hdr_valid_m), .m_eth_hdr_ready(1'b1),
    .m_eth_dest_mac(p_dest_m), .m_eth_src_mac(p_src_m), .m_eth_type(p_type_m),
    .m_eth_payload_axis_tdata(p_tdata_m),
    .m_eth_payload_axis_tvalid(p_tvalid_m),
    .m_eth_payload_axis_tready(1'b1),
    .m_eth_payload_axis_tlast(p_tlast_m),
    .m_eth_payload_axis_tuser(p_tuser_m),
    .m_sel(p_sel), .busy(p_busy)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // ---------------- frame sources ----------------
  bit          active [CH];
  bit          hdr_pend [CH];
  bit          vhold [CH];
  int          gap [CH];
  int          flen [CH];
  int          fbeat [CH];
  logic [7:0]  fdata [CH][8];
  bit          fuser [CH][8];
  logic [47:0] fdst [CH];
  logic [47:0] fsrc [CH];
  logic [15:0] ftype [CH];

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 header offered, 2 payload
  int          phase = 0;
  int          msel  = 0;
  int          ptr   = 0;
  logic [47:0] e_dst = '0, e_src = '0;
  logic [15:0] e_type = '0;
  int          frames_seen = 0;

  task automatic new_frame(input int i);
    active[i]   = 1'b1;
    flen[i]     = $urandom_range(5, 1);
    fbeat[i]    = 0;
    hdr_pend[i] = !RAW[i];
    vhold[i]    = 1'b0;
    fdst[i]     = {16'($urandom()), $urandom()};
    fsrc[i]     = {16'($urandom()), $urandom()};
    ftype[i]    = 16'($urandom());
    for (int b = 0; b < 8; b++) begin
      fdata[i][b] = 8'($urandom());
      fuser[i][b] = 1'($urandom());
    end
  endtask

  // Drive all inputs for the coming cycle (called just after a clock edge).
  task automatic drive_inputs();
    for (int i = 0; i < CH; i++) begin
      if (!active[i]) begin
        if (gap[i] > 0) gap[i]--;
        else new_frame(i);
      end
      s_eth_hdr_valid[i] = active[i] && hdr_pend[i];
      if (active[i] && !hdr_pend[i]) begin
        vhold[i] = vhold[i] || ($urandom_range(3) != 0);
      end else begin
        vhold[i] = 1'b0;
      end
      s_eth_payload_axis_tvalid[i]      = vhold[i];
      s_eth_dest_mac[i*48 +: 48]        = fdst[i];
      s_eth_src_mac[i*48 +: 48]         = fsrc[i];
      s_eth_type[i*16 +: 16]            = ftype[i];
      s_eth_payload_axis_tdata[i*DW +: DW] = fdata[i][fbeat[i]];
      s_eth_payload_axis_tlast[i]       = active[i] && (fbeat[i] == flen[i] - 1);
      s_eth_payload_axis_tuser[i]       = fuser[i][fbeat[i]];
    end
    local_mac                 = {16'($urandom()), $urandom()};
    m_eth_hdr_ready           = ($urandom_range(9) < 6);
    m_eth_payload_axis_tready = ($urandom_range(9) < 7);
  endtask

  // Check the outputs against the model, then advance the model to the next edge.
  task automatic check_and_step();
    logic [CH-1:0] req;
    logic [CH-1:0] exp_hr;
    logic [CH-1:0] exp_tr;
    logic          exp_mv;
    int            win;
    int            idx;
    for (int i = 0; i < CH; i++) begin
      req[i] = RAW[i] ? s_eth_payload_axis_tvalid[i] : s_eth_hdr_valid[i];
    end
    win = -1;
    if (phase == 0) begin
      for (int off = 0; off < CH; off++) begin
        idx = (ptr + off) % CH;
        if (win < 0 && req[idx]) win = idx;
      end
    end
    exp_hr = '0;
    if (win >= 0 && !RAW[win]) exp_hr[win] = 1'b1;
    exp_tr = '0;
    exp_mv = 1'b0;
    if (phase == 2) begin
      exp_tr[msel] = m_eth_payload_axis_tready;
      exp_mv       = s_eth_payload_axis_tvalid[msel];
    end

    check("hdr_ready", s_eth_hdr_ready, exp_hr);
    check("busy", busy, phase != 0);
    check("m_hdr_valid", m_eth_hdr_valid, phase == 1);
    check("m_sel", m_sel, msel);
    check("s_tready", s_eth_payload_axis_tready, exp_tr);
    check("m_tvalid", m_eth_payload_axis_tvalid, exp_mv);
    if (phase == 1) begin
      check("hdr_dest", m_eth_dest_mac, e_dst);
      check("hdr_src", m_eth_src_mac, e_src);
      check("hdr_type", m_eth_type, e_type);
    end
    if (exp_mv) begin
      check("m_tdata", m_eth_payload_axis_tdata, fdata[msel][fbeat[msel]]);
      check("m_tlast", m_eth_payload_axis_tlast, fbeat[msel] == flen[msel] - 1);
      check("m_tuser", m_eth_payload_axis_tuser, fuser[msel][fbeat[msel]]);
    end
    if (m_eth_payload_axis_tvalid && m_eth_payload_axis_tready && m_eth_payload_axis_tlast) begin
      frames_seen++;
    end

    case (phase)
      0: if (win >= 0) begin
        phase = 1;
        msel  = win;
        if (RAW[win]) begin
          e_dst  = 48'h011B19000000;
          e_src  = local_mac;
          e_type = 16'h88F7;
        end else begin
          e_dst         = fdst[win];
          e_src         = fsrc[win];
          e_type        = ftype[win];
          hdr_pend[win] = 1'b0;
        end
      end
      1: if (m_eth_hdr_ready) phase = 2;
      default: if (s_eth_payload_axis_tvalid[msel] && m_eth_payload_axis_tready) begin
        vhold[msel] = 1'b0;
        if (fbeat[msel] == flen[msel] - 1) begin
          active[msel] = 1'b0;
          gap[msel]    = $urandom_range(3);
          phase        = 0;
          ptr          = (msel + 1) % CH;
        end else begin
          fbeat[msel]++;
        end
      end
    endcase
  endtask

  // Reset in the middle of a frame: everything must drop at once.
  task automatic inject_reset();
    rst = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_hdr_valid", m_eth_hdr_valid, 1'b0);
    check("rst_m_tvalid", m_eth_payload_axis_tvalid, 1'b0);
    check("rst_s_tready", s_eth_payload_axis_tready, '0);
    check("rst_hdr_ready", s_eth_hdr_ready, '0);
    check("rst_m_sel", m_sel, 0);
    check("rst_dest", m_eth_dest_mac, 0);
    active[msel] = 1'b0;
    gap[msel]    = 2;
    phase        = 0;
    msel         = 0;
    ptr          = 0;
    e_dst        = '0;
    e_src        = '0;
    e_type       = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int nhdr;
    for (int i = 0; i < CH; i++) begin
      active[i] = 1'b0;
      gap[i]    = $urandom_range(3);
      fbeat[i]  = 0;
      flen[i]   = 1;
    end

    // Reset state: the sources are idle and every output is 0.
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_hdr_valid", m_eth_hdr_valid, 1'b0);
    check("reset_m_sel", m_sel, 0);
    check("reset_hdr_fields", {m_eth_dest_mac, m_eth_type}, 64'h0);
    check("reset_src", m_eth_src_mac, 48'h0);
    check("reset_m_tvalid", m_eth_payload_axis_tvalid, 1'b0);
    check("reset_s_tready", s_eth_payload_axis_tready, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      drive_inputs();
      @(negedge clk);
      check_and_step();
      if (cyc % 1000 == 500 && phase == 2 && fbeat[msel] >= 1) begin
        inject_reset();
      end else begin
        @(posedge clk);
        #1;
      end
    end
    check("frames_completed", frames_seen > 200, 1'b1);

    // Priority DUT: channel 0 requests on every cycle, so it wins every frame.
    nhdr = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("prio_hdr_ready_ch1", p_hdr_ready[1], 1'b0);
      if (p_hdr_valid_m) begin
        check("prio_sel", p_sel, 1'b0);
        check("prio_type", p_type_m, 16'h0800);
        nhdr++;
      end
    end
    check("prio_frame_count", nhdr >= 4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eth_tx_frame_arb.md
Name: eth_tx_frame_arb

Overview:
N-channel Ethernet transmit frame arbiter. It sits between the frame sources and eth_axis_tx: the UDP/IP stack output, raw PTP payload generators, and any future sources. It grants one channel per frame and forwards that channel's Ethernet header and payload as a single coherent frame. Channels flagged "raw" supply payload only; the block builds their header from parameters and local_mac, so no source-side header-valid pulse generation is needed.

Parameters:
CHANNELS, 2, number of input channels (1..16)
DATA_WIDTH, 8, payload tdata width
ARB_MODE, "ROUND_ROBIN", "ROUND_ROBIN" or "PRIORITY" (lowest index wins)
RAW_MASK, 0, bit i = 1: channel i is raw (payload only, header generated)
RAW_ETH_TYPE, 16'h88F7, ethertype inserted for raw channels
RAW_DEST_MAC, 48'h011B19000000, destination MAC inserted for raw channels
SEL_WIDTH, $clog2(CHANNELS) min 1, width of m_sel

Ports:
clk  in  1  logic clock
rst  in  1  asynchronous reset, active high
s_eth_hdr_valid  in  CHANNELS  per-channel header valid (ignored for raw channels)
s_eth_hdr_ready  out  CHANNELS  per-channel header accept
s_eth_dest_mac  in  CHANNELS*48  packed, channel 0 in LSBs
s_eth_src_mac  in  CHANNELS*48  packed
s_eth_type  in  CHANNELS*16  packed
s_eth_payload_axis_tdata  in  CHANNELS*DATA_WIDTH  packed
s_eth_payload_axis_tvalid  in  CHANNELS
s_eth_payload_axis_tready  out  CHANNELS
s_eth_payload_axis_tlast  in  CHANNELS
s_eth_payload_axis_tuser  in  CHANNELS
local_mac  in  48  source MAC for raw channels
m_eth_hdr_valid  out  1
m_eth_hdr_ready  in  1
m_eth_dest_mac  out  48
m_eth_src_mac  out  48
m_eth_type  out  16
m_eth_payload_axis_tdata  out  DATA_WIDTH
m_eth_payload_axis_tvalid  out  1
m_eth_payload_axis_tready  in  1
m_eth_payload_axis_tlast  out  1
m_eth_payload_axis_tuser  out  1
m_sel  out  SEL_WIDTH  channel currently granted
busy  out  1  high while not IDLE

Behaviour:
- Clocking: one clock, clk. rst is asynchronous and active high. On rst: state IDLE, rr pointer 0, m_sel 0, header registers 0. All outputs 0 except the pass-through payload, which is gated to 0 because no channel is granted.
- Request: req[i] = s_eth_payload_axis_tvalid[i] for a raw channel, s_eth_hdr_valid[i] for any other channel.
- States:
  - IDLE → HDR when any req is set. The winner is chosen combinationally: PRIORITY takes the lowest set index; ROUND_ROBIN takes the first set index at or after the pointer, wrapping modulo CHANNELS.
  - Same cycle as the IDLE → HDR transition:
    - m_sel is registered.
    - Non-raw winner: s_eth_hdr_ready[winner] pulses 1 for exactly that cycle, and its dest/src/type are latched.
    - Raw winner: RAW_DEST_MAC, local_mac and RAW_ETH_TYPE are latched.
  - HDR: m_eth_hdr_valid = 1 with the latched fields, held stable. On m_eth_hdr_ready → PAYLOAD.
  - PAYLOAD: combinational pass-through of the granted channel only:
    - m_tdata, m_tvalid, m_tlast and m_tuser come from channel m_sel.
    - s_tready[m_sel] = m_eth_payload_axis_tready; all other trees are 0.
    - On tvalid & tready & tlast → IDLE. In ROUND_ROBIN the pointer becomes (m_sel+1) mod CHANNELS.
- s_eth_hdr_ready is never asserted for raw channels. s_tready is 0 for every channel in IDLE and HDR, so a raw channel's first beat is held at its source until PAYLOAD.
- Latency: request seen in IDLE cycle N → m_eth_hdr_valid at N+1. Minimum one IDLE cycle between back-to-back frames.
- Requests arriving or dropping while a grant is held are ignored until return to IDLE. The grant persists through payload stalls of any length.
- Single-beat frame (tlast on the first beat) completes in one PAYLOAD cycle.
- CHANNELS=1: no arbitration, m_sel is constant 0, same state sequence.
- rst asserted mid-frame: the frame is abandoned immediately and the partial frame is not terminated (the downstream is reset on the same rst).
- tuser is forwarded unmodified. No checksum or length processing is performed.

Test Plan:
1. CHANNELS=2, RAW_MASK=2'b01. Ch0 sends a 3-beat payload 0xA1,0xA2,0xA3 → one header with dest 01:1B:19:00:00:00, src=local_mac, type 0x88F7 one cycle after tvalid, then 3 beats, last flagged; s_eth_hdr_ready[0] stays 0.
2. Ch1 (non-raw) hdr type 0x0800 and ch0 raw request in the same cycle, ROUND_ROBIN, pointer 0 → ch0 frame first, then ch1 frame with type 0x0800. s_eth_hdr_ready[1] pulses exactly once.
3. ARB_MODE="PRIORITY", both channels requesting continuously for 4 frames → all 4 grants go to ch0. ROUND_ROBIN under the same stimulus → grants alternate 0,1,0,1.
4. m_eth_hdr_ready held 0 for 5 cycles, then m_tready toggled 1,0,1,0 during a 4-beat frame → header fields and valid stay stable; data is accepted only on ready-high cycles; no other channel's tready rises.
5. CHANNELS=4, requests only on ch3 and ch1, pointer 2 → ch3 granted, then ch1 (wrap-around).
6. rst asserted during beat 2 of a 5-beat frame → all valids and readys 0 that cycle; busy 0; after release, a new request produces a fresh header starting with the pointer at 0.
